// File: rtl/cnt_ctrl_if.sv
// -----------------------------------------------------------------------------
// cnt_ctrl_if -- register-bus write port into the 64-bit timer counter.
//
// Signals:
//   tdr0_wr_sel : write strobe for TDR0 (counter bits [31:0]) this cycle
//   tdr1_wr_sel : write strobe for TDR1 (counter bits [63:32]) this cycle
//   wdata       : 32-bit bus write data, shared by both words
//   pstrb       : byte-lane strobes qualifying wdata
//
// Modports:
//   master : bus side, drives the write strobes and data
//   slave  : counter side, samples them
// -----------------------------------------------------------------------------
interface cnt_ctrl_if;
  logic        tdr0_wr_sel;
  logic        tdr1_wr_sel;
  logic [31:0] wdata;
  logic [3:0]  pstrb;

  modport master (output tdr0_wr_sel, output tdr1_wr_sel, output wdata, output pstrb);
  modport slave  (input  tdr0_wr_sel, input  tdr1_wr_sel, input  wdata, input  pstrb);
endinterface

// File: rtl/cnt_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_ctrl -- 64-bit free-running timer counter with run/halt/idle control,
// byte-maskable TDR0/TDR1 loads and an optional power-of-two prescaler.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   timer_en     : counter enable (TCR[0])
//   div_en       : prescaler enable (TCR[1])
//   div_val      : prescaler exponent (TCR[11:8]); 9..15 behave as 8
//   halt         : debug halt request (THCSR[1])
//   bus          : cnt_ctrl_if.slave, TDR0/TDR1 write port
//   count_0/1    : counter low / high word
//   cnt_tick     : one-cycle pulse after each increment edge
//   cnt_ovf      : one-cycle pulse after a 64-bit wrap to zero
//   state        : 00 IDLE, 01 RUN, 10 HALTED
//
// Configuration macro: TMR_PRESCALER_EN
//   defined   -> 8-bit prescaler divider is compiled in
//   undefined -> no divider; the counter advances on every RUN cycle
// -----------------------------------------------------------------------------
module cnt_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        halt,
  cnt_ctrl_if.slave   bus,
  output logic [31:0] count_0,
  output logic [31:0] count_1,
  output logic        cnt_tick,
  output logic        cnt_ovf,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] count_0_r;
  logic [31:0] count_1_r;
  logic [31:0] count_0_nxt_s;
  logic [31:0] count_1_nxt_s;
  logic        cnt_tick_r;
  logic        cnt_ovf_r;
  logic        tick_s;
  logic        wr_any_s;
  logic        clr_s;
  logic        inc_s;
  logic        wrap_s;
  logic [63:0] cnt_inc_s;

  // Replace the byte lanes selected by strb with new data, keep the rest.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

`ifdef TMR_PRESCALER_EN
  logic [7:0] div_cnt_r;
  logic [7:0] div_cnt_nxt_s;
  logic [7:0] div_lim_s;

  // Divider terminal count 2^div_val - 1, exponents above 8 clamp to 255.
  always_comb begin
    div_lim_s = 8'hFF;
    if (div_val > 4'd8) begin
      div_lim_s = 8'hFF;
    end else begin
      div_lim_s = 8'((16'd1 << div_val) - 16'd1);
    end
  end

  assign tick_s = div_en ? (div_cnt_r == div_lim_s) : 1'b1;

  // Divider next value: cleared by writes, disable and IDLE; frozen in HALTED.
  always_comb begin
    div_cnt_nxt_s = div_cnt_r;
    if (wr_any_s || clr_s || (state_r == IDLE)) begin
      div_cnt_nxt_s = 8'd0;
    end else if (state_r == RUN) begin
      div_cnt_nxt_s = tick_s ? 8'd0 : (div_cnt_r + 8'd1);
    end else begin
      div_cnt_nxt_s = div_cnt_r;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= 8'd0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
    end
  end
`else
  // Without the prescaler the divider controls have no effect.
  logic unused_div_s;
  assign unused_div_s = ^{div_en, div_val};
  assign tick_s       = 1'b1;
`endif

  // Next state depends only on the enable and halt inputs, from any state.
  always_comb begin
    state_nxt_s = IDLE;
    if (!timer_en) begin
      state_nxt_s = IDLE;
    end else if (halt) begin
      state_nxt_s = HALTED;
    end else begin
      state_nxt_s = RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign wr_any_s  = bus.tdr0_wr_sel | bus.tdr1_wr_sel;
  // Leaving RUN/HALTED for IDLE wipes the count.
  assign clr_s     = (state_r != IDLE) && !timer_en;
  // Any TDR write blocks the increment for both words on that edge.
  assign inc_s     = (state_r == RUN) && timer_en && tick_s && !wr_any_s;
  assign cnt_inc_s = {count_1_r, count_0_r} + 64'd1;
  assign wrap_s    = &{count_1_r, count_0_r};

  // Per-word next count: write > clear-on-disable > increment > hold.
  always_comb begin
    count_0_nxt_s = count_0_r;
    count_1_nxt_s = count_1_r;
    if (bus.tdr0_wr_sel) begin
      count_0_nxt_s = byte_merge(count_0_r, bus.wdata, bus.pstrb);
    end else if (clr_s) begin
      count_0_nxt_s = 32'd0;
    end else if (inc_s) begin
      count_0_nxt_s = cnt_inc_s[31:0];
    end else begin
      count_0_nxt_s = count_0_r;
    end
    if (bus.tdr1_wr_sel) begin
      count_1_nxt_s = byte_merge(count_1_r, bus.wdata, bus.pstrb);
    end else if (clr_s) begin
      count_1_nxt_s = 32'd0;
    end else if (inc_s) begin
      count_1_nxt_s = cnt_inc_s[63:32];
    end else begin
      count_1_nxt_s = count_1_r;
    end
  end

  // Counter words and the registered tick/overflow pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_0_r  <= 32'd0;
      count_1_r  <= 32'd0;
      cnt_tick_r <= 1'b0;
      cnt_ovf_r  <= 1'b0;
    end else begin
      count_0_r  <= count_0_nxt_s;
      count_1_r  <= count_1_nxt_s;
      cnt_tick_r <= inc_s;
      cnt_ovf_r  <= inc_s && wrap_s;
    end
  end

  assign count_0  = count_0_r;
  assign count_1  = count_1_r;
  assign cnt_tick = cnt_tick_r;
  assign cnt_ovf  = cnt_ovf_r;
  assign state    = state_r;

endmodule

// File: tb/tb_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnt_ctrl -- directed self-checking bench for cnt_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Prescaler cases are compiled in only with TMR_PRESCALER_EN.
// -----------------------------------------------------------------------------
module tb_cnt_ctrl;
  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        timer_en = 1'b0;
  logic        div_en   = 1'b0;
  logic [3:0]  div_val  = 4'd0;
  logic        halt     = 1'b0;
  logic [31:0] count_0;
  logic [31:0] count_1;
  logic        cnt_tick;
  logic        cnt_ovf;
  logic [1:0]  state;
  int          n_tests  = 0;
  int          n_fail   = 0;

  cnt_ctrl_if bus ();

  cnt_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .halt     (halt),
    .bus      (bus),
    .count_0  (count_0),
    .count_1  (count_1),
    .cnt_tick (cnt_tick),
    .cnt_ovf  (cnt_ovf),
    .state    (state)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] c1, input logic [31:0] c0,
                           input logic tk, input logic ov, input logic [1:0] st);
    check_val({tag, ".count_1"}, {32'd0, count_1}, {32'd0, c1});
    check_val({tag, ".count_0"}, {32'd0, count_0}, {32'd0, c0});
    check_val({tag, ".tick"}, {63'd0, cnt_tick}, {63'd0, tk});
    check_val({tag, ".ovf"}, {63'd0, cnt_ovf}, {63'd0, ov});
    check_val({tag, ".state"}, {62'd0, state}, {62'd0, st});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-edge TDR write; sel picks TDR1 when 1, TDR0 when 0.
  task automatic tdr_write(input logic sel, input logic [31:0] data, input logic [3:0] strb);
    bus.tdr0_wr_sel = !sel;
    bus.tdr1_wr_sel = sel;
    bus.wdata       = data;
    bus.pstrb       = strb;
    step(1);
    bus.tdr0_wr_sel = 1'b0;
    bus.tdr1_wr_sel = 1'b0;
  endtask

  initial begin
    bus.tdr0_wr_sel = 1'b0;
    bus.tdr1_wr_sel = 1'b0;
    bus.wdata       = 32'd0;
    bus.pstrb       = 4'd0;

    // Reset state.
    #2 rst_n = 1'b0;
    step(2);
    check_all("reset", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);

    // Count once per cycle from 0, first increment on the second edge.
    rst_n    = 1'b1;
    timer_en = 1'b1;
    step(1);
    check_all("run_start", 32'd0, 32'd0, 1'b0, 1'b0, 2'b01);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check_all($sformatf("run%0d", i), 32'd0, i, 1'b1, 1'b0, 2'b01);
    end

    // Full-word then byte-masked TDR0 loads block the increment.
    tdr_write(1'b0, 32'h1122_3344, 4'b1111);
    check_all("tdr0_full", 32'd0, 32'h1122_3344, 1'b0, 1'b0, 2'b01);
    tdr_write(1'b0, 32'hAABB_CCDD, 4'b0101);
    check_all("tdr0_mask", 32'd0, 32'h11BB_33DD, 1'b0, 1'b0, 2'b01);
    step(1);
    check_all("after_mask", 32'd0, 32'h11BB_33DE, 1'b1, 1'b0, 2'b01);

    // 64-bit wrap.
    tdr_write(1'b1, 32'hFFFF_FFFF, 4'b1111);
    check_all("tdr1_load", 32'hFFFF_FFFF, 32'h11BB_33DE, 1'b0, 1'b0, 2'b01);
    tdr_write(1'b0, 32'hFFFF_FFFE, 4'b1111);
    check_all("tdr0_load", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 2'b01);
    step(1);
    check_all("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'b01);
    step(1);
    check_all("wrap", 32'd0, 32'd0, 1'b1, 1'b1, 2'b01);
    step(1);
    check_all("post_wrap", 32'd0, 32'd1, 1'b1, 1'b0, 2'b01);

    // Halt for 5 cycles at 0x10 (halt raised on the load edge), then resume.
    halt = 1'b1;
    tdr_write(1'b0, 32'h0000_0010, 4'b1111);
    for (int i = 1; i <= 5; i++) begin
      check_all($sformatf("halt%0d", i), 32'd0, 32'h10, 1'b0, 1'b0, 2'b10);
      step(1);
    end
    halt = 1'b0;
    check_all("halt_end", 32'd0, 32'h10, 1'b0, 1'b0, 2'b10);
    step(1);
    check_all("resume_run", 32'd0, 32'h10, 1'b0, 1'b0, 2'b01);
    step(1);
    check_all("resume_inc", 32'd0, 32'h11, 1'b1, 1'b0, 2'b01);

    // Disable at count 5 clears on the next edge.
    tdr_write(1'b0, 32'h0000_0005, 4'b1111);
    check_all("load5", 32'd0, 32'h5, 1'b0, 1'b0, 2'b01);
    timer_en = 1'b0;
    step(1);
    check_all("disable", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);

    // Writes land in IDLE and hold there.
    tdr_write(1'b0, 32'hCAFE_1234, 4'b0011);
    check_all("idle_wr", 32'd0, 32'h0000_1234, 1'b0, 1'b0, 2'b00);
    step(2);
    check_all("idle_hold", 32'd0, 32'h0000_1234, 1'b0, 1'b0, 2'b00);

    // Re-enable from a preloaded value, then reset mid-run.
    timer_en = 1'b1;
    step(3);
    check_all("reenable", 32'd0, 32'h0000_1236, 1'b1, 1'b0, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
    step(2);
    rst_n = 1'b1;
    step(1);
    check_all("rst_release", 32'd0, 32'd0, 1'b0, 1'b0, 2'b01);

    // HALTED -> IDLE also clears.
    step(2);
    halt = 1'b1;
    step(2);
    check_val("halted_state", {62'd0, state}, {62'd0, 2'b10});
    timer_en = 1'b0;
    step(1);
    check_all("halt_disable", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
    halt = 1'b0;

`ifdef TMR_PRESCALER_EN
    // div_val=2: one increment every 4 RUN cycles.
    div_en   = 1'b1;
    div_val  = 4'd2;
    timer_en = 1'b1;
    step(4);
    check_all("div2_pre", 32'd0, 32'd0, 1'b0, 1'b0, 2'b01);
    step(1);
    check_all("div2_1", 32'd0, 32'd1, 1'b1, 1'b0, 2'b01);
    step(4);
    check_all("div2_2", 32'd0, 32'd2, 1'b1, 1'b0, 2'b01);
    timer_en = 1'b0;
    step(1);
    // div_val=12 clamps to 256.
    div_val  = 4'd12;
    timer_en = 1'b1;
    step(256);
    check_all("div12_pre", 32'd0, 32'd0, 1'b0, 1'b0, 2'b01);
    step(1);
    check_all("div12_1", 32'd0, 32'd1, 1'b1, 1'b0, 2'b01);
`else
    // Prescaler controls are ignored when it is not built.
    div_en   = 1'b1;
    div_val  = 4'd2;
    timer_en = 1'b1;
    step(3);
    check_all("nodiv", 32'd0, 32'd2, 1'b1, 1'b0, 2'b01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
